bpsk_modulator: RTL and testbench
=================================

Name: bpsk_modulator

Overview:
- Transmit-side counterpart of the BPSK demodulator: accepts parallel DATA_WIDTH-bit words over a valid/ready handshake and serializes them MSB first.
- Each bit lasts one carrier period of SAMPLE_NUMBER samples. Bit 1 emits sine_in; bit 0 emits neg_sine_in.
- Drives the carrier phase index cnt_out to the external combinational sine LUT, which returns sine_in/neg_sine_in in the same cycle.
- Sits between the framing logic and the DAC/channel model.

Parameters:
SAMPLE_NUMBER, 256, samples per carrier period (= per bit); power of two.
SAMPLE_WIDTH, 12, width of carrier samples and signal_out.
DATA_WIDTH, 12, bits per word.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  sample strobe; one output sample per clk with en=1
data_in  in  DATA_WIDTH  word to transmit
data_valid  in  1  data_in valid
data_ready  out  1  block can accept a word this cycle (combinational)
sine_in  in  SAMPLE_WIDTH  LUT sine at address cnt_out
neg_sine_in  in  SAMPLE_WIDTH  LUT negated sine at address cnt_out
cnt_out  out  $clog2(SAMPLE_NUMBER)  carrier phase index
signal_out  out  SAMPLE_WIDTH  modulated sample (registered)
busy  out  1  high while in SEND

Behaviour:
- Reset (async, immediate) sets:
  - signal_out=0, cnt_out=0, busy=0
  - state=IDLE, shift register and bit counter cleared
- After reset, data_ready=1.
- States:
  - IDLE: data_ready=1, signal_out=0, cnt_out held at 0. On data_valid: latch data_in into the shift register, bit_cnt=0, go to SEND. en is not required for acceptance.
  - SEND: on each en, register signal_out = (current bit ? sine_in : neg_sine_in), where current bit is shreg MSB, then increment cnt_out.
    - cnt_out wrap from SAMPLE_NUMBER-1 to 0 ends the bit: shift left by one, bit_cnt++.
    - With en=0, every register holds, including signal_out.
- data_ready in SEND = en && cnt_out==SAMPLE_NUMBER-1 && bit_cnt==DATA_WIDTH-1. Otherwise 0.
- Last sample with data_valid=1: load the new word, stay in SEND, cnt_out wraps to 0. Zero-gap back-to-back transfer.
- Last sample with data_valid=0: go to IDLE; signal_out becomes 0 on the following clock.
- Latency: the first modulated sample appears on signal_out on the first en edge after the accept cycle.
- Each word produces exactly DATA_WIDTH*SAMPLE_NUMBER samples.
- data_in is ignored while data_ready=0.
- Reset mid-word aborts the transfer. No partial-word recovery.
- cnt_out is pure binary and wraps naturally, since SAMPLE_NUMBER is a power of two.

Optional Feature:
- Macro: BPSK_DIFF_EN (DBPSK).
- When defined, the transmitted bit is e = e_prev XOR data_bit.
  - e_prev is forced to 1 at reset and on every IDLE->SEND transition.
  - e_prev carries across back-to-back words.
  - e drives the sine/neg_sine select with the same mapping (1 -> sine).
- When not defined, the raw data bit drives the select; no e_prev register exists.

Decomposition:
- Shared header bpsk_defs.vh holds:
  - state encodings (IDLE=1'b0, SEND=1'b1)
  - symbol mapping constants (BIT1_SINE=1), shared with bpsk_demodulator2.
- One natural sub-module: bpsk_serializer. It contains the shift register, bit_cnt and the last-bit flag, with load/shift inputs.
- Phase counter and output mux stay in the top.

Test Plan (SAMPLE_NUMBER=4, DATA_WIDTH=4, LUT sine={0,100,0,-100}, neg = negation):
- Reset mid-stream, rst pulsed between edges -> outputs immediately signal_out=0, cnt_out=0, busy=0, data_ready=1.
- Word 4'b1010, en=1 constant, single valid pulse -> 16 samples: 0,100,0,-100 / 0,-100,0,100 / 0,100,0,-100 / 0,-100,0,100; then 0. data_ready high only in IDLE and in the 16th sample cycle.
- Words 4'b1111 then 4'b0000, data_valid held -> 32 contiguous samples, no idle zero between words; cnt_out sequence 0..3 repeated 8 times.
- en high 1 cycle in 3, word 4'b1000 -> each sample held 3 clk; transfer spans 48 clk; cnt_out advances only on en.
- rst asserted after 6 samples of 4'b1100, next word 4'b0001 -> clean restart at cnt_out=0; first 4 samples are neg_sine.
- BPSK_DIFF_EN, word 4'b1100 -> encoded 0,1,1,1: neg, sine, sine, sine periods. Back-to-back 4'b0001 continues from e_prev=1: encoded 1,1,1,0.

Source files
------------

// File: rtl/bpsk_modulator_pkg.sv
// Shared definitions for the BPSK modulator: FSM state encoding and symbol mapping.
// The symbol mapping matches the one used by the receive side.
package bpsk_modulator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic BIT1_SINE = 1'b1;

    function automatic logic sel_sine(input logic tx_bit);
        return (tx_bit == BIT1_SINE);
    endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// Word handshake between the framing logic (master) and the BPSK modulator (slave).
interface bpsk_modulator_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/bpsk_modulator_serializer.sv
// MSB-first word serializer: shift register plus bit counter with a last-bit flag.
module bpsk_modulator_serializer #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  bit_o,
    output logic                  last_o
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;

    // Load takes priority so a back-to-back word replaces the finished one.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shreg_d   = data_i;
            bit_cnt_d = '0;
        end else if (shift_i) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_o  = shreg_q[DATA_WIDTH-1];
    assign last_o = (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: serializes words MSB first, one carrier period per bit.
// Define BPSK_DIFF_EN for differential (DBPSK) encoding of the transmitted bits.
module bpsk_modulator
    import bpsk_modulator_pkg::*;
#(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    bpsk_modulator_if.slave                   s_bus,
    input  logic [SAMPLE_WIDTH-1:0]           sine_in_i,
    input  logic [SAMPLE_WIDTH-1:0]           neg_sine_in_i,
    output logic [$clog2(SAMPLE_NUMBER)-1:0]  cnt_out_o,
    output logic [SAMPLE_WIDTH-1:0]           signal_out_o,
    output logic                              busy_o
);
    localparam int CW = $clog2(SAMPLE_NUMBER);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(SAMPLE_NUMBER - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] signal_q, signal_d;

    logic data_bit_s;
    logic last_bit_s;
    logic tx_bit_s;
    logic wrap_s;
    logic ready_s;
    logic accept_s;
    logic shift_s;

    assign wrap_s   = (state_q == ST_SEND) && en_i && (cnt_q == LAST_SAMPLE);
    assign ready_s  = (state_q == ST_IDLE) || (wrap_s && last_bit_s);
    assign accept_s = s_bus.data_valid && ready_s;
    assign shift_s  = wrap_s && !last_bit_s;

    assign s_bus.data_ready = ready_s;

    bpsk_modulator_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_s),
        .shift_i (shift_s),
        .data_i  (s_bus.data_in),
        .bit_o   (data_bit_s),
        .last_o  (last_bit_s)
    );

`ifdef BPSK_DIFF_EN
    logic e_prev_q, e_prev_d;

    assign tx_bit_s = e_prev_q ^ data_bit_s;

    // Reference bit restarts at 1 on each new transfer and carries across back-to-back words.
    always_comb begin
        e_prev_d = e_prev_q;
        if (state_q == ST_IDLE) begin
            if (accept_s) begin
                e_prev_d = 1'b1;
            end else begin
                e_prev_d = e_prev_q;
            end
        end else if (wrap_s) begin
            e_prev_d = tx_bit_s;
        end else begin
            e_prev_d = e_prev_q;
        end
    end

    // Differential reference register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_prev_q <= 1'b1;
        end else begin
            e_prev_q <= e_prev_d;
        end
    end
`else
    assign tx_bit_s = data_bit_s;
`endif

    // Next-state, phase counter and output sample selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signal_d = signal_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                signal_d = '0;
                if (accept_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (en_i) begin
                    signal_d = sel_sine(tx_bit_s) ? sine_in_i : neg_sine_in_i;
                    cnt_d    = cnt_q + CW'(1);
                    if (wrap_s && last_bit_s && !accept_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d  = ST_SEND;
                    cnt_d    = cnt_q;
                    signal_d = signal_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                signal_d = '0;
            end
        endcase
    end

    // State, phase counter and output sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            signal_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
        end
    end

    assign cnt_out_o    = cnt_q;
    assign signal_out_o = signal_q;
    assign busy_o       = (state_q == ST_SEND);

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator: directed scenarios plus random traffic
// against a sample-queue reference model (honours BPSK_DIFF_EN when defined).
module tb_bpsk_modulator;
    localparam int SN    = 4;
    localparam int SW    = 12;
    localparam int DW    = 4;
    localparam int CW    = 2;
    localparam int TOTAL = DW * SN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [SW-1:0] sine;
    logic [SW-1:0] neg;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sig;
    logic          busy;

    bpsk_modulator_if #(.DATA_WIDTH(DW)) bus ();

    bpsk_modulator #(
        .SAMPLE_NUMBER (SN),
        .SAMPLE_WIDTH  (SW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .s_bus         (bus),
        .sine_in_i     (sine),
        .neg_sine_in_i (neg),
        .cnt_out_o     (cnt),
        .signal_out_o  (sig),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    logic [SW-1:0] lut [SN];
    assign sine = lut[cnt];
    assign neg  = -lut[cnt];

    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] q [$];
    logic [SW-1:0] exp_sig;
    logic          e_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Append the whole sample stream of one word to the expected queue.
    task automatic push_word(input logic [DW-1:0] w, input logic from_idle);
        logic b;
        if (from_idle) e_model = 1'b1;
        for (int i = DW - 1; i >= 0; i--) begin
`ifdef BPSK_DIFF_EN
            b = e_model ^ w[i];
            e_model = b;
`else
            b = w[i];
`endif
            for (int k = 0; k < SN; k++) begin
                q.push_back(b ? lut[k] : -lut[k]);
            end
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [DW-1:0] d);
        logic exp_rdy;
        logic acc;
        logic was_idle;
        int   exp_cnt;
        @(negedge clk);
        en = e;
        bus.data_valid = v;
        bus.data_in = d;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && e);
        chk("data_ready", {31'd0, bus.data_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        was_idle = (q.size() == 0);
        @(posedge clk);
        if (q.size() > 0) begin
            if (e) exp_sig = q.pop_front();
        end else begin
            exp_sig = '0;
        end
        if (acc) push_word(d, was_idle);
        #1;
        exp_cnt = (q.size() == 0) ? 0 : (TOTAL - q.size()) % SN;
        chk("signal_out", {20'd0, sig}, {20'd0, exp_sig});
        chk("cnt_out", {30'd0, cnt}, 32'(exp_cnt));
        chk("busy", {31'd0, busy}, {31'd0, (q.size() > 0)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_signal_out", {20'd0, sig}, 32'd0);
        chk("rst_cnt_out", {30'd0, cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd1);
        q.delete();
        exp_sig = '0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        lut[0] = 12'sd0;
        lut[1] = 12'sd100;
        lut[2] = 12'sd0;
        lut[3] = -12'sd100;
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        exp_sig = '0;
        e_model = 1'b1;
        #12;
        chk("reset_signal_out", {20'd0, sig}, 32'd0);
        chk("reset_cnt_out", {30'd0, cnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data_ready", {31'd0, bus.data_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single word, en held high.
        step(1'b1, 1'b1, 4'b1010);
        repeat (19) step(1'b1, 1'b0, 4'b0000);

        // Back-to-back words with valid held.
        step(1'b1, 1'b1, 4'b1111);
        repeat (15) step(1'b1, 1'b1, 4'b0000);
        repeat (18) step(1'b1, 1'b0, 4'b0000);

        // Sparse sample strobe: en one cycle in three.
        step(1'b0, 1'b1, 4'b1000);
        repeat (17) begin
            step(1'b1, 1'b0, 4'b0000);
            step(1'b0, 1'b0, 4'b0000);
            step(1'b0, 1'b0, 4'b0000);
        end

        // Abort mid-word, then restart cleanly.
        step(1'b1, 1'b1, 4'b1100);
        repeat (6) step(1'b1, 1'b0, 4'b0000);
        do_reset();
        step(1'b1, 1'b1, 4'b0001);
        repeat (18) step(1'b1, 1'b0, 4'b0000);

        // Back-to-back 1100 then 0001 (differential carry-over when enabled).
        step(1'b1, 1'b1, 4'b1100);
        repeat (15) step(1'b1, 1'b1, 4'b0001);
        repeat (18) step(1'b1, 1'b0, 4'b0000);

        // Random traffic with one random mid-stream reset.
        for (int n = 0; n < 900; n++) begin
            if (n == 450) do_reset();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), DW'($urandom));
        end
        repeat (40) step(1'b1, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
